// File: rtl/app_mul_err_stats.sv
// ---------------------------------------------------------------------------
// app_mul_err_stats
// Collects error statistics for the output of an approximate multiplier.
// Each accepted sample is a pair of 32-bit products: the exact result and the
// approximate (Mitchell) result. Over a window of WINDOW samples the block
// accumulates:
//   - the saturating sum of absolute errors
//   - the largest absolute error
//   - the number of samples with a nonzero error
//   - the number of samples accepted
// The results are held for readout after the window ends.
//
// Pipeline:
//   stage 1  registers |exact - approx| in the cycle the sample is accepted
//   stage 2  folds that error into the statistics
//
// Control is a four-state FSM: IDLE -> RUN -> DRAIN -> DONE.
//
// Optional feature: when the macro APP_MUL_ERR_HIST_EN is defined, eight
// saturating 16-bit histogram bins are built, indexed by the leading-one
// position of the error. Otherwise hist_count is tied to zero.
// ---------------------------------------------------------------------------
module app_mul_err_stats #(
    parameter int unsigned WINDOW = 1024,
    parameter int unsigned SUM_W  = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      prod_exact,
    input  logic [31:0]      prod_approx,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sample_cnt,
    output logic [31:0]      mismatch_cnt,
    output logic [SUM_W-1:0] err_sum,
    output logic [31:0]      err_max,
    input  logic [2:0]       hist_sel,
    output logic [15:0]      hist_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0]      WIN     = 32'(WINDOW);
    // The sum is one bit wider than its widest operand, so an overflow past
    // the saturation point is always visible before it is clamped.
    localparam int unsigned      ACC_W   = ((SUM_W > 32) ? SUM_W : 32) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    state_t state_q, state_d;
    logic   drain_q, drain_d;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_err_q,   s1_err_d;

    logic [31:0]      sample_cnt_q,   sample_cnt_d;
    logic [31:0]      mismatch_cnt_q, mismatch_cnt_d;
    logic [SUM_W-1:0] err_sum_q,      err_sum_d;
    logic [31:0]      err_max_q,      err_max_d;

    logic             accept;
    logic             clear;
    logic [31:0]      abs_err;
    logic [ACC_W-1:0] sum_wide;

    // A sample is only taken in RUN, and only while the window still has room.
    assign in_ready = (state_q == ST_RUN) && (sample_cnt_q < WIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign err_sum      = err_sum_q;
    assign err_max      = err_max_q;

    // Next-state logic. A start clears the statistics and (re)opens a window.
    // A start in DONE is ignored.
    always_comb begin
        // NOTE: every variable written here gets a default value first.
        // Otherwise a path that leaves one unassigned would infer a latch.
        state_d      = state_q;
        drain_d      = drain_q;
        clear        = 1'b0;
        sample_cnt_d = sample_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                clear = start;
            end
            ST_DRAIN: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end else if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A sample that arrives with a restart becomes the first sample of
        // the new window. The count never exceeds WIN, so it cannot wrap.
        sample_cnt_d = (clear ? 32'd0 : sample_cnt_q) + {31'd0, accept};

        // The last sample of the window was taken this cycle. Two DRAIN cycles
        // follow while stage 1 and stage 2 empty, then DONE.
        if ((state_q == ST_RUN) && accept && (sample_cnt_d == WIN)) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
        end
    end

    // Stage 1: capture the absolute error of the sample being accepted.
    always_comb begin
        abs_err    = (prod_exact >= prod_approx) ? (prod_exact - prod_approx)
                                                 : (prod_approx - prod_exact);
        s1_valid_d = accept;
        s1_err_d   = accept ? abs_err : s1_err_q;
    end

    // Stage 2: fold the stage-1 error into the statistics. A restart clears
    // the statistics and drops any error still in flight.
    always_comb begin
        err_sum_d      = err_sum_q;
        err_max_d      = err_max_q;
        mismatch_cnt_d = mismatch_cnt_q;
        sum_wide       = ACC_W'(err_sum_q) + ACC_W'(s1_err_q);
        if (clear) begin
            err_sum_d      = '0;
            err_max_d      = '0;
            mismatch_cnt_d = '0;
        end else if (s1_valid_q) begin
            err_sum_d = (sum_wide > ACC_W'(SUM_MAX)) ? SUM_MAX
                                                     : sum_wide[SUM_W-1:0];
            if (s1_err_q > err_max_q) begin
                err_max_d = s1_err_q;
            end
            if ((s1_err_q != 32'd0) && (mismatch_cnt_q != '1)) begin
                mismatch_cnt_d = mismatch_cnt_q + 32'd1;
            end
        end
    end

    // State, pipeline and statistics registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned non-blocking. Every register
        // then samples the value it had before the edge, whatever the order
        // of the statements.
        if (reset) begin
            state_q        <= ST_IDLE;
            drain_q        <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_err_q       <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            err_sum_q      <= '0;
            err_max_q      <= '0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            s1_valid_q     <= s1_valid_d;
            s1_err_q       <= s1_err_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            err_sum_q      <= err_sum_d;
            err_max_q      <= err_max_d;
        end
    end

`ifdef APP_MUL_ERR_HIST_EN
    logic [15:0] bins_q [8];
    logic [15:0] bins_d [8];
    logic [15:0] hist_count_q, hist_count_d;
    logic [2:0]  bin_idx;

    // Map an error to its bin. Bin 0 is a zero error. Bins 1..6 each cover
    // four leading-one positions. Bin 7 covers positions 24 and above.
    function automatic logic [2:0] bin_of(input logic [31:0] e);
        logic [2:0] b;
        if (e == 32'd0)        b = 3'd0;
        else if (|e[31:24])    b = 3'd7;
        else if (|e[23:20])    b = 3'd6;
        else if (|e[19:16])    b = 3'd5;
        else if (|e[15:12])    b = 3'd4;
        else if (|e[11:8])     b = 3'd3;
        else if (|e[7:4])      b = 3'd2;
        else                   b = 3'd1;
        return b;
    endfunction

    // Histogram update in stage 2, alongside the other statistics.
    always_comb begin
        bins_d       = bins_q;
        bin_idx      = bin_of(s1_err_q);
        hist_count_d = bins_q[hist_sel];
        if (clear) begin
            for (int i = 0; i < 8; i++) begin
                bins_d[i] = '0;
            end
        end else if (s1_valid_q && (bins_q[bin_idx] != '1)) begin
            bins_d[bin_idx] = bins_q[bin_idx] + 16'd1;
        end
    end

    // Bin storage and the registered readout port.
    always_ff @(posedge clk) begin
        // NOTE: the bins are reset here like any other register. They are
        // part of the visible state and must read zero after a reset.
        if (reset) begin
            bins_q       <= '{default: '0};
            hist_count_q <= '0;
        end else begin
            bins_q       <= bins_d;
            hist_count_q <= hist_count_d;
        end
    end

    assign hist_count = hist_count_q;
`else
    // No histogram is built, so the select input has no effect.
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = 16'd0;
`endif

endmodule

// File: tb/tb_app_mul_err_stats.sv
// ---------------------------------------------------------------------------
// Testbench for app_mul_err_stats (WINDOW=4, SUM_W=33).
// The reference model keeps the accepted errors of the current window in a
// queue, each tagged with the cycle in which it was accepted. The expected
// statistics in cycle c are computed from the samples accepted at or before
// cycle c-2. The expected sample count includes every sample accepted before
// cycle c. After the last accept of a window, done is expected three cycles
// later.
// ---------------------------------------------------------------------------
module tb_app_mul_err_stats;

    localparam int WINDOW = 4;
    localparam int SUM_W  = 33;
    localparam longint unsigned SUM_MAX_L = (64'd1 << SUM_W) - 64'd1;
`ifdef APP_MUL_ERR_HIST_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      prod_exact;
    logic [31:0]      prod_approx;
    logic             busy;
    logic             done;
    logic [31:0]      sample_cnt;
    logic [31:0]      mismatch_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [31:0]      err_max;
    logic [2:0]       hist_sel;
    logic [15:0]      hist_count;

    always #5 clk = ~clk;

    app_mul_err_stats #(
        .WINDOW(WINDOW),
        .SUM_W (SUM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .prod_exact  (prod_exact),
        .prod_approx (prod_approx),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .mismatch_cnt(mismatch_cnt),
        .err_sum     (err_sum),
        .err_max     (err_max),
        .hist_sel    (hist_sel),
        .hist_count  (hist_count)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned err;
        int          acc;
    } samp_t;

    samp_t q[$];
    bit    win_open;
    int    final_cyc;
    int    cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic int bin_of(input int unsigned e);
        int pos;
        if (e == 0) return 0;
        pos = 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) pos = i;
        end
        return (pos >= 24) ? 7 : pos / 4 + 1;
    endfunction

    function automatic int bin_count(input int sel);
        int n;
        n = 0;
        foreach (q[i]) begin
            if (bin_of(q[i].err) == sel) n++;
        end
        return n;
    endfunction

    // Drives one cycle of stimulus, checks the DUT against the model for the
    // current cycle, then advances the clock and the model.
    task automatic step(input bit rs, input bit st, input bit v,
                        input int unsigned a, input int unsigned b);
        longint unsigned sum;
        int unsigned     mx;
        int unsigned     mis;
        bit              exp_ready, exp_busy, exp_done, acc;
        samp_t           s;
        reset       = rs;
        start       = st;
        in_valid    = v;
        prod_exact  = a;
        prod_approx = b;
        #1;
        exp_ready = win_open && (q.size() < WINDOW);
        exp_busy  = win_open || (final_cyc >= 0 && cyc > final_cyc && cyc <= final_cyc + 2);
        exp_done  = (final_cyc >= 0) && (cyc == final_cyc + 3);
        sum = 0;
        mx  = 0;
        mis = 0;
        foreach (q[i]) begin
            if (q[i].acc <= cyc - 2) begin
                sum = sum + 64'(q[i].err);
                if (sum > SUM_MAX_L) sum = SUM_MAX_L;
                if (q[i].err > mx) mx = q[i].err;
                if (q[i].err != 0) mis++;
            end
        end
        check("in_ready",     64'(in_ready),     64'(exp_ready));
        check("busy",         64'(busy),         64'(exp_busy));
        check("done",         64'(done),         64'(exp_done));
        check("sample_cnt",   64'(sample_cnt),   64'(q.size()));
        check("err_sum",      64'(err_sum),      sum);
        check("err_max",      64'(err_max),      64'(mx));
        check("mismatch_cnt", 64'(mismatch_cnt), 64'(mis));
        @(posedge clk);
        #1;
        acc = v && exp_ready;
        if (rs) begin
            q.delete();
            win_open  = 1'b0;
            final_cyc = -1;
        end else begin
            if (st && !exp_done) begin
                q.delete();
                win_open  = 1'b1;
                final_cyc = -1;
            end
            if (acc) begin
                s.err = abs_diff(a, b);
                s.acc = cyc;
                q.push_back(s);
                if (q.size() == WINDOW) begin
                    win_open  = 1'b0;
                    final_cyc = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Walk hist_sel over all bins; each readout is valid one cycle after the
    // select changes.
    task automatic hist_sweep();
        for (int sel = 0; sel < 8; sel++) begin
            hist_sel = 3'(sel);
            idle(1);
            check("hist_count", 64'(hist_count), HIST_EN ? 64'(bin_count(sel)) : 64'd0);
        end
    endtask

    initial begin
        int unsigned a, b;
        reset       = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        prod_exact  = '0;
        prod_approx = '0;
        hist_sel    = '0;
        win_open    = 1'b0;
        final_cyc   = -1;
        cyc         = 0;
        @(posedge clk);
        #1;

        // Reset state, with reset still held.
        step(1'b1, 1'b0, 1'b1, 9, 1);
        check("reset_hist", 64'(hist_count), 64'd0);

        // Basic window: errors 0, 4, 10, 0.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 100, 100);
        step(1'b0, 1'b0, 1'b1, 100, 96);
        step(1'b0, 1'b0, 1'b1, 50, 60);
        step(1'b0, 1'b0, 1'b1, 7, 7);
        idle(5);
        check("t1_sample_cnt",   64'(sample_cnt),   64'd4);
        check("t1_mismatch_cnt", 64'(mismatch_cnt), 64'd2);
        check("t1_err_sum",      64'(err_sum),      64'd14);
        check("t1_err_max",      64'(err_max),      64'd10);
        hist_sweep();

        // in_valid held for six cycles: only four samples are accepted.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 20 + i, 3 * i);
        idle(4);
        check("t2_sample_cnt", 64'(sample_cnt), 64'd4);

        // Saturation of the 33-bit sum.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
        step(1'b0, 1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b0, 1'b1, 1, 1);
        idle(5);
        check("t3_err_sum", 64'(err_sum), 64'h1_FFFF_FFFF);
        check("t3_err_max", 64'(err_max), 64'hFFFF_FFFF);

        // Restart after two samples, then a full window of (10,13).
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1000, 1);
        step(1'b0, 1'b0, 1'b1, 2000, 3);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 10, 13);
        idle(5);
        check("t4_sample_cnt", 64'(sample_cnt), 64'd4);
        check("t4_err_sum",    64'(err_sum),    64'd12);

        // Reset in the middle of RUN; in_valid is then ignored until start.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 40, 1);
        step(1'b0, 1'b0, 1'b1, 40, 2);
        step(1'b1, 1'b0, 1'b1, 40, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 77, 1);
        check("t5_busy",       64'(busy),       64'd0);
        check("t5_sample_cnt", 64'(sample_cnt), 64'd0);
        check("t5_err_sum",    64'(err_sum),    64'd0);

        // One error in each of bins 0, 1, 2 and 7.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 5, 5);
        step(1'b0, 1'b0, 1'b1, 3, 0);
        step(1'b0, 1'b0, 1'b1, 16, 0);
        step(1'b0, 1'b0, 1'b1, 32'h0100_0000, 0);
        idle(5);
        hist_sweep();

        // Random traffic with occasional starts and resets.
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(2))
                0:       b = a;
                1:       b = a + $urandom_range(15);
                default: b = $urandom;
            endcase
            step(($urandom % 128) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0, a, b);
        end
        idle(6);
        hist_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
